gpio_cmd_controller: RTL and testbench

GPIO_CMD_CONTROLLER -- requirements
Module: gpio_cmd_controller

---
 rtl/gpio_cmd_controller.sv | 181 ++++++++++++++++++
 tb/tb_gpio_cmd_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cmd_controller.sv
// Host-GPIO command decoder for a multi-channel acquisition front end.
// One registered command word per write/release handshake; drives FIFO control, DAC and trigger levels.
module gpio_cmd_controller #(
  parameter int NCH     = 2,
  parameter int LVW     = 14,
  parameter int RST_LEN = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 RESET_in,
  input  logic [31:0]          SELECT_in,
  input  logic [NCH*32-1:0]    DATA_in,
  input  logic [NCH*16-1:0]    DATAcnt_in,
  input  logic [NCH-1:0]       full_in,
  output logic [31:0]          GPIO_out,
  output logic                 BUSY_out,
  output logic                 _RESET_out,
  output logic                 SLEEP_out,
  output logic [NCH-1:0]       DATAread_out,
  output logic [LVW-1:0]       ANALOG_out,
  output logic [NCH*LVW-1:0]   H_TRGLEVEL_out,
  output logic [NCH*LVW-1:0]   L_TRGLEVEL_out
);

  localparam logic [6:0] OP_START = 7'h01;
  localparam logic [6:0] OP_INQ   = 7'h02;
  localparam logic [6:0] OP_READ  = 7'h04;
  localparam logic [6:0] OP_STOP  = 7'h08;
  localparam logic [6:0] OP_DAC   = 7'h10;
  localparam logic [6:0] OP_HLVL  = 7'h20;
  localparam logic [6:0] OP_LLVL  = 7'h40;

  localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (RD_LAT > 0) ? CW'(RD_LAT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RWAIT,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     sel_q;
  logic [31:0]     cmd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     gpio_q, gpio_d;
  logic            rstn_q;
  logic [7:0]      rcnt_q;
  logic            sleep_q;
  logic [LVW-1:0]  analog_q;

  logic [31:0]     data_a [4];
  logic [15:0]     cnt_a  [4];
  logic            full_a [4];

  logic [6:0]      opc;
  logic [1:0]      ch;
  logic [15:0]     payload;
  logic            ch_ok;
  logic            sel_onehot;
  logic            rd_go;
  logic            rd_strobe;
  logic            unused_bits;

  // Pad per-channel inputs to four entries so the 2-bit channel field indexes safely.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      if (gi < NCH) begin : g_on
        assign data_a[gi] = DATA_in[gi*32 +: 32];
        assign cnt_a[gi]  = DATAcnt_in[gi*16 +: 16];
        assign full_a[gi] = full_in[gi];
      end else begin : g_off
        assign data_a[gi] = '0;
        assign cnt_a[gi]  = '0;
        assign full_a[gi] = 1'b0;
      end
    end
  endgenerate

  assign opc         = cmd_q[6:0];
  assign ch          = cmd_q[9:8];
  assign payload     = cmd_q[31:16];
  assign unused_bits = ^cmd_q;
  assign ch_ok       = (int'(ch) < NCH);
  assign sel_onehot  = (sel_q[6:0] != 7'd0) && ((sel_q[6:0] & (sel_q[6:0] - 7'd1)) == 7'd0);
  assign rd_go       = (opc == OP_READ) && ch_ok && (cnt_a[ch] != 16'd0);
  assign rd_strobe   = (state_q == S_EXEC) && rd_go && !RESET_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gpio_d  = gpio_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sel_onehot) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_HOLD;
        case (opc)
          OP_INQ:  gpio_d = ch_ok ? {15'd0, full_a[ch], cnt_a[ch]} : 32'hFFFF_FFFF;
          OP_READ: begin
            if (!rd_go)           gpio_d  = 32'hFFFF_FFFF;
            else if (RD_LAT == 0) gpio_d  = data_a[ch];
            else                  state_d = S_RWAIT;
          end
          OP_HLVL, OP_LLVL: if (!ch_ok) gpio_d = 32'hFFFF_FFFF;
          default: ;
        endcase
      end
      S_RWAIT: begin
        if (cnt_q == CNT_LAST) begin
          gpio_d  = data_a[ch];
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: if (sel_q[6:0] == 7'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET_in) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      gpio_q   <= '0;
      rstn_q   <= 1'b1;
      rcnt_q   <= '0;
      sleep_q  <= 1'b1;
      analog_q <= '0;
    end else begin
      sel_q   <= SELECT_in;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gpio_q  <= gpio_d;
      if (state_q == S_IDLE) cmd_q <= sel_q;
      // The reset pulse runs on its own counter so releasing HOLD early cannot cut it short.
      if (state_q == S_EXEC && opc == OP_START) begin
        rstn_q  <= 1'b0;
        rcnt_q  <= 8'(RST_LEN - 1);
        sleep_q <= 1'b1;
      end else if (!rstn_q) begin
        if (rcnt_q == 8'd0) rstn_q <= 1'b1;
        else                rcnt_q <= rcnt_q - 8'd1;
      end
      if (state_q == S_EXEC && opc == OP_STOP) sleep_q  <= 1'b0;
      if (state_q == S_EXEC && opc == OP_DAC)  analog_q <= payload[LVW-1:0];
    end
  end

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic [LVW-1:0] h_q, l_q;
      always_ff @(posedge clk) begin
        if (RESET_in) begin
          h_q <= '0;
          l_q <= '0;
        end else if (state_q == S_EXEC && ch == 2'(gi)) begin
          if (opc == OP_HLVL) h_q <= payload[LVW-1:0];
          if (opc == OP_LLVL) l_q <= payload[LVW-1:0];
        end
      end
      assign H_TRGLEVEL_out[gi*LVW +: LVW] = h_q;
      assign L_TRGLEVEL_out[gi*LVW +: LVW] = l_q;
      assign DATAread_out[gi]              = rd_strobe && (ch == 2'(gi));
    end
  endgenerate

  assign GPIO_out   = gpio_q;
  assign BUSY_out   = (state_q != S_IDLE);
  assign _RESET_out = rstn_q;
  assign SLEEP_out  = sleep_q;
  assign ANALOG_out = analog_q;

endmodule

// File: tb/tb_gpio_cmd_controller.sv
// Self-checking bench: directed and random host commands against a transaction-level model.
module tb_gpio_cmd_controller;
  localparam int NCH     = 2;
  localparam int LVW     = 14;
  localparam int RST_LEN = 4;
  localparam int RD_LAT  = 2;

  logic               clk = 1'b0;
  logic               RESET_in;
  logic [31:0]        SELECT_in;
  logic [NCH*32-1:0]  DATA_in;
  logic [NCH*16-1:0]  DATAcnt_in;
  logic [NCH-1:0]     full_in;
  logic [31:0]        GPIO_out;
  logic               BUSY_out;
  logic               _RESET_out;
  logic               SLEEP_out;
  logic [NCH-1:0]     DATAread_out;
  logic [LVW-1:0]     ANALOG_out;
  logic [NCH*LVW-1:0] H_TRGLEVEL_out;
  logic [NCH*LVW-1:0] L_TRGLEVEL_out;

  always #5 clk = ~clk;

  gpio_cmd_controller #(.NCH(NCH), .LVW(LVW), .RST_LEN(RST_LEN), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .RESET_in(RESET_in), .SELECT_in(SELECT_in), .DATA_in(DATA_in),
    .DATAcnt_in(DATAcnt_in), .full_in(full_in), .GPIO_out(GPIO_out), .BUSY_out(BUSY_out),
    ._RESET_out(_RESET_out), .SLEEP_out(SLEEP_out), .DATAread_out(DATAread_out),
    .ANALOG_out(ANALOG_out), .H_TRGLEVEL_out(H_TRGLEVEL_out), .L_TRGLEVEL_out(L_TRGLEVEL_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0]    m_gpio;
  logic [LVW-1:0] m_analog;
  logic           m_sleep;
  logic [LVW-1:0] m_h [NCH];
  logic [LVW-1:0] m_l [NCH];

  // FIFO model: word becomes valid exactly RD_LAT cycles after a strobe, junk otherwise
  logic [31:0]    f_word [NCH];
  logic [15:0]    f_cnt  [NCH];
  logic           f_full [NCH];
  logic [7:0]     strb_hist [NCH];

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      logic [7:0] nh;
      nh = {strb_hist[c][6:0], DATAread_out[c]};
      strb_hist[c] <= nh;
      DATA_in[c*32 +: 32] <= nh[RD_LAT-1] ? f_word[c] : ~f_word[c];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_fifo(input int c, input int cnt, input bit full, input logic [31:0] word);
    f_cnt[c]  = 16'(cnt);
    f_full[c] = full;
    f_word[c] = word;
    DATAcnt_in[c*16 +: 16] = 16'(cnt);
    full_in[c] = full;
  endtask

  task automatic model_reset();
    m_gpio   = '0;
    m_analog = '0;
    m_sleep  = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      m_h[c] = '0;
      m_l[c] = '0;
    end
  endtask

  task automatic check_state(input string pfx);
    check({pfx, "_gpio"}, GPIO_out, m_gpio);
    check({pfx, "_analog"}, 32'(ANALOG_out), 32'(m_analog));
    check({pfx, "_sleep"}, 32'(SLEEP_out), 32'(m_sleep));
    for (int c = 0; c < NCH; c++) begin
      check({pfx, "_hlvl"}, 32'(H_TRGLEVEL_out[c*LVW +: LVW]), 32'(m_h[c]));
      check({pfx, "_llvl"}, 32'(L_TRGLEVEL_out[c*LVW +: LVW]), 32'(m_l[c]));
    end
  endtask

  // Write a code, hold it for 'hold' cycles, release, and compare everything seen.
  task automatic run_cmd(input logic [31:0] code, input int hold);
    logic [6:0]  op = code[6:0];
    int          c = int'(code[9:8]);
    logic [15:0] pl = code[31:16];
    bit          valid = ($countones(op) == 1);
    bit          chv = (c < NCH);
    bit          is_start = valid && (op == 7'h01);
    bit          exp_strb;
    int          low_n = 0, first_low = -1, strb_n = 0, strb_at = -1;
    logic [NCH-1:0] strb_mask = '0;
    logic        b1 = 1'b0, b2 = 1'b0, bh, br1, br2;

    exp_strb = valid && (op == 7'h04) && chv && (f_cnt[c] != 16'd0);
    if (valid) begin
      case (op)
        7'h01: m_sleep = 1'b1;
        7'h02: m_gpio = chv ? {15'd0, f_full[c], f_cnt[c]} : 32'hFFFF_FFFF;
        7'h04: m_gpio = exp_strb ? f_word[c] : 32'hFFFF_FFFF;
        7'h08: m_sleep = 1'b0;
        7'h10: m_analog = pl[LVW-1:0];
        7'h20: if (chv) m_h[c] = pl[LVW-1:0]; else m_gpio = 32'hFFFF_FFFF;
        7'h40: if (chv) m_l[c] = pl[LVW-1:0]; else m_gpio = 32'hFFFF_FFFF;
        default: ;
      endcase
    end

    @(negedge clk);
    SELECT_in = code;
    for (int i = 1; i <= hold + 2; i++) begin
      @(negedge clk);
      if (!_RESET_out) begin
        low_n++;
        if (first_low < 0) first_low = i;
      end
      if (|DATAread_out) begin
        strb_n++;
        strb_mask |= DATAread_out;
        if (strb_at < 0) strb_at = i;
      end
      if (i == 1) b1 = BUSY_out;
      if (i == 2) b2 = BUSY_out;
      if (i == hold) begin
        bh = BUSY_out;
        SELECT_in = $urandom & 32'hFFFF_FF80;
      end
      if (i == hold + 1) br1 = BUSY_out;
      if (i == hold + 2) br2 = BUSY_out;
    end

    check("busy_idle", 32'(b1), 32'd0);
    check("busy_exec", 32'(b2), 32'(valid));
    check("busy_hold", 32'(bh), 32'(valid));
    check("busy_rel", 32'(br1), 32'(valid));
    check("busy_done", 32'(br2), 32'd0);
    check("rst_low_n", low_n, is_start ? RST_LEN : 0);
    if (is_start) check("rst_first", first_low, 3);
    check("strb_n", strb_n, exp_strb ? 1 : 0);
    if (exp_strb) begin
      check("strb_at", strb_at, 2);
      check("strb_ch", 32'(strb_mask), 32'(1 << c));
    end
    check_state("cmd");
    $display("txn code=%h gpio=%h busy_seen=%0d strobes=%0d rst_low=%0d", code, GPIO_out, b2, strb_n, low_n);
  endtask

  initial begin
    RESET_in   = 1'b1;
    SELECT_in  = '0;
    DATAcnt_in = '0;
    full_in    = '0;
    DATA_in    = '0;
    for (int c = 0; c < NCH; c++) begin
      strb_hist[c] = '0;
      set_fifo(c, 0, 1'b0, 32'h0);
    end
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(BUSY_out), 32'd0);
    check("rst_rstn", 32'(_RESET_out), 32'd1);
    check("rst_strb", 32'(DATAread_out), 32'd0);
    check_state("rst");
    RESET_in = 1'b0;
    @(negedge clk);

    // Start pulse and handshake timing
    run_cmd(32'h0000_0001, 10);
    // Inquiry, valid and out-of-range channel
    set_fifo(1, 5, 1'b1, 32'h1111_2222);
    run_cmd(32'h0000_0102, 10);
    check("inq_const", GPIO_out, 32'h0001_0005);
    run_cmd(32'h0000_0302, 10);
    check("inq_badch", GPIO_out, 32'hFFFF_FFFF);
    // Read with data, then read of an empty FIFO
    set_fifo(0, 3, 1'b0, 32'hA5A5_1234);
    run_cmd(32'h0000_0004, 10);
    check("read_const", GPIO_out, 32'hA5A5_1234);
    set_fifo(0, 0, 1'b0, 32'h5555_AAAA);
    run_cmd(32'h0000_0004, 10);
    check("read_empty", GPIO_out, 32'hFFFF_FFFF);
    // Levels and DAC
    run_cmd(32'h3FFF_0120, 10);
    run_cmd(32'h1234_0010, 10);
    check("dac_const", 32'(ANALOG_out), 32'h1234);
    // Long-held codes execute once
    set_fifo(1, 7, 1'b0, 32'hCAFE_F00D);
    run_cmd(32'h0000_0104, 100);
    run_cmd(32'h0000_0001, 100);
    // Stop, then a multi-bit code that must be ignored
    run_cmd(32'h0000_0008, 10);
    check("stop_sleep", 32'(SLEEP_out), 32'd0);
    run_cmd(32'h0000_0003, 10);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] rnd;
      logic [6:0]  op;
      int          r, a, b;
      for (int c = 0; c < NCH; c++)
        set_fifo(c, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535)),
                 1'($urandom_range(0, 1)), $urandom);
      r = int'($urandom_range(0, 8));
      if (r < 7) op = 7'(1 << r);
      else if (r == 7) op = 7'd0;
      else begin
        a = int'($urandom_range(0, 6));
        b = (a + 1 + int'($urandom_range(0, 5))) % 7;
        op = 7'((1 << a) | (1 << b));
      end
      rnd = $urandom;
      run_cmd({rnd[31:10], 2'($urandom_range(0, 3)), 1'b0, op}, 10);
    end

    // Reset while waiting for read data
    set_fifo(0, 3, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    SELECT_in = 32'h0000_0004;
    repeat (3) @(negedge clk);
    check("rw_busy", 32'(BUSY_out), 32'd1);
    RESET_in = 1'b1;
    model_reset();
    @(negedge clk);
    check("rw_rst_busy", 32'(BUSY_out), 32'd0);
    check("rw_rst_rstn", 32'(_RESET_out), 32'd1);
    check("rw_rst_strb", 32'(DATAread_out), 32'd0);
    check_state("rw_rst");
    RESET_in  = 1'b0;
    SELECT_in = '0;
    repeat (4) @(negedge clk);
    check("rw_after_gpio", GPIO_out, 32'd0);
    check("rw_after_busy", 32'(BUSY_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
